// File: rtl/trig_acq_pkg.sv
// Shared types and defaults for the acquisition trigger sequencer.
package trig_acq_pkg;

    localparam int unsigned ST_W       = 3;
    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_TO_W   = 48;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_PRE_FILL = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POST     = 3'd3,
        ST_DONE     = 3'd4
    } acq_state_e;

endpackage

// File: rtl/trig_edge_qual.sv
// Registers the qualified trigger level and produces a holdoff-gated rising-edge strobe.
module trig_edge_qual (
    input  logic clk_200M,
    input  logic rst,
    input  logic trig_in,
    input  logic holdoff_active,
    output logic trig_ok_c
);

    logic trig_d;

    always_ff @(posedge clk_200M or posedge rst) begin
        if (rst) begin
            trig_d <= 1'b0;
        end else begin
            trig_d <= trig_in;
        end
    end

    assign trig_ok_c = trig_in & ~trig_d & ~holdoff_active;

endmodule

// File: rtl/trig_acq_ctrl.sv
// DSO acquisition sequencer: pre-trigger fill, trigger/auto accept, post-trigger capture,
// and holdoff handshake, driving a circular capture RAM.
module trig_acq_ctrl
    import trig_acq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned TO_W   = DEF_TO_W
) (
    input  logic              clk_200M,
    input  logic              rst,
    input  logic              acq_start,
    input  logic              acq_stop,
    input  logic              auto_mode,
    input  logic [ADDR_W-1:0] pre_trig_depth,
    input  logic [ADDR_W-1:0] post_trig_depth,
    input  logic [TO_W-1:0]   auto_timeout,
    input  logic              trig_in,
    input  logic              holdoff_active,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              trig_forced,
    output logic              acq_done,
    output logic              holdoff_reload_n,
    output logic              trig_aft_pul,
    output logic [ST_W-1:0]   state_o
);

    localparam logic [ADDR_W:0]   RAM_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

    acq_state_e        state;
    logic [ADDR_W-1:0] pre_depth;
    logic [ADDR_W-1:0] post_depth;
    logic [TO_W-1:0]   auto_to;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [TO_W-1:0]   auto_cnt;

    logic              trig_ok_c;
    logic [ADDR_W-1:0] post_eff_c;
    logic [ADDR_W-1:0] pre_eff_c;
    logic [ADDR_W:0]   depth_sum_c;

    trig_edge_qual u_edge_qual (
        .clk_200M       (clk_200M),
        .rst            (rst),
        .trig_in        (trig_in),
        .holdoff_active (holdoff_active),
        .trig_ok_c      (trig_ok_c)
    );

    // Depth legalisation at latch time: post of 0 means 1, pre shrinks so both fit the RAM.
    always_comb begin
        post_eff_c  = (post_trig_depth == '0) ? ADDR_ONE : post_trig_depth;
        depth_sum_c = {1'b0, pre_trig_depth} + {1'b0, post_eff_c};
        pre_eff_c   = pre_trig_depth;
        if (depth_sum_c > RAM_DEPTH) begin
            pre_eff_c = ADDR_W'(RAM_DEPTH - {1'b0, post_eff_c});
        end
    end

    always_ff @(posedge clk_200M or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            pre_depth        <= '0;
            post_depth       <= '0;
            auto_to          <= '0;
            pre_cnt          <= '0;
            post_cnt         <= '0;
            auto_cnt         <= '0;
            wr_en            <= 1'b0;
            wr_addr          <= '0;
            trig_addr        <= '0;
            trig_forced      <= 1'b0;
            acq_done         <= 1'b0;
            holdoff_reload_n <= 1'b0;
            trig_aft_pul     <= 1'b0;
        end else begin
            trig_aft_pul <= 1'b0;
            if (wr_en) begin
                wr_addr <= wr_addr + ADDR_ONE;
            end

            if (acq_stop) begin
                state            <= ST_IDLE;
                wr_en            <= 1'b0;
                acq_done         <= 1'b0;
                holdoff_reload_n <= 1'b0;
            end else if (acq_start) begin
                pre_depth        <= pre_eff_c;
                post_depth       <= post_eff_c;
                auto_to          <= auto_timeout;
                pre_cnt          <= '0;
                post_cnt         <= '0;
                auto_cnt         <= '0;
                state            <= (pre_eff_c == '0) ? ST_ARMED : ST_PRE_FILL;
                wr_en            <= 1'b1;
                acq_done         <= 1'b0;
                holdoff_reload_n <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                    end
                    ST_PRE_FILL: begin
                        pre_cnt <= pre_cnt + ADDR_ONE;
                        if (pre_cnt == pre_depth - ADDR_ONE) begin
                            state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        auto_cnt <= auto_cnt + TO_ONE;
                        // A real edge takes precedence over the auto timeout in the same cycle.
                        if (trig_ok_c || (auto_mode && (auto_cnt == auto_to))) begin
                            trig_addr   <= wr_addr;
                            trig_forced <= ~trig_ok_c;
                            post_cnt    <= ADDR_ONE;
                            if (post_depth == ADDR_ONE) begin
                                state        <= ST_DONE;
                                wr_en        <= 1'b0;
                                acq_done     <= 1'b1;
                                trig_aft_pul <= 1'b1;
                            end else begin
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        post_cnt <= post_cnt + ADDR_ONE;
                        if (post_cnt + ADDR_ONE == post_depth) begin
                            state        <= ST_DONE;
                            wr_en        <= 1'b0;
                            acq_done     <= 1'b1;
                            trig_aft_pul <= 1'b1;
                        end
                    end
                    default: begin
                        state            <= ST_IDLE;
                        wr_en            <= 1'b0;
                        acq_done         <= 1'b0;
                        holdoff_reload_n <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_o = ST_W'(state);

endmodule

// File: tb/tb_trig_acq_ctrl.sv
// Self-checking bench for trig_acq_ctrl: directed vector table, corner-case sequences,
// and randomized traffic against a transaction-level reference model.
module tb_trig_acq_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned TO_W   = 16;
    localparam int DEPTH = 16;

    localparam int S_IDLE  = 0;
    localparam int S_PRE   = 1;
    localparam int S_ARMED = 2;
    localparam int S_POST  = 3;
    localparam int S_DONE  = 4;

    logic              clk_200M = 1'b0;
    logic              rst = 1'b1;
    logic              acq_start = 1'b0;
    logic              acq_stop = 1'b0;
    logic              auto_mode = 1'b0;
    logic [ADDR_W-1:0] pre_trig_depth = '0;
    logic [ADDR_W-1:0] post_trig_depth = '0;
    logic [TO_W-1:0]   auto_timeout = '0;
    logic              trig_in = 1'b0;
    logic              holdoff_active = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] trig_addr;
    logic              trig_forced;
    logic              acq_done;
    logic              holdoff_reload_n;
    logic              trig_aft_pul;
    logic [2:0]        state_o;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state (plain integers, down/up counters of samples)
    int m_st, m_addr, m_taddr;
    int m_pre_left, m_post_total, m_post_cnt, m_to, m_armed;
    bit m_wr, m_done, m_rel, m_pul, m_forced, m_prev;

    trig_acq_ctrl #(.ADDR_W(ADDR_W), .TO_W(TO_W)) dut (
        .clk_200M         (clk_200M),
        .rst              (rst),
        .acq_start        (acq_start),
        .acq_stop         (acq_stop),
        .auto_mode        (auto_mode),
        .pre_trig_depth   (pre_trig_depth),
        .post_trig_depth  (post_trig_depth),
        .auto_timeout     (auto_timeout),
        .trig_in          (trig_in),
        .holdoff_active   (holdoff_active),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .trig_addr        (trig_addr),
        .trig_forced      (trig_forced),
        .acq_done         (acq_done),
        .holdoff_reload_n (holdoff_reload_n),
        .trig_aft_pul     (trig_aft_pul),
        .state_o          (state_o)
    );

    always #5 clk_200M = ~clk_200M;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_addr = 0; m_taddr = 0;
        m_pre_left = 0; m_post_total = 0; m_post_cnt = 0; m_to = 0; m_armed = 0;
        m_wr = 0; m_done = 0; m_rel = 0; m_pul = 0; m_forced = 0; m_prev = 0;
    endtask

    task automatic model_enter_done();
        m_st = S_DONE; m_wr = 0; m_done = 1; m_pul = 1;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit rise;
        int old_addr, pre_eff, post_eff;
        rise = trig_in && !m_prev && !holdoff_active;
        old_addr = m_addr;
        m_pul = 0;
        if (m_wr) m_addr = (m_addr + 1) % DEPTH;
        if (acq_stop) begin
            m_st = S_IDLE; m_wr = 0; m_done = 0; m_rel = 0;
        end else if (acq_start) begin
            post_eff = (post_trig_depth == 0) ? 1 : int'(post_trig_depth);
            pre_eff = int'(pre_trig_depth);
            if (pre_eff + post_eff > DEPTH) pre_eff = DEPTH - post_eff;
            m_pre_left = pre_eff; m_post_total = post_eff;
            m_to = int'(auto_timeout); m_armed = 0; m_post_cnt = 0;
            m_st = (pre_eff == 0) ? S_ARMED : S_PRE;
            m_wr = 1; m_rel = 1; m_done = 0;
        end else if (m_st == S_PRE) begin
            m_pre_left--;
            if (m_pre_left == 0) m_st = S_ARMED;
        end else if (m_st == S_ARMED) begin
            if (rise || (auto_mode && m_armed == m_to)) begin
                m_forced = !rise;
                m_taddr = old_addr;
                m_post_cnt = 1;
                if (m_post_cnt >= m_post_total) model_enter_done();
                else m_st = S_POST;
            end
            m_armed++;
        end else if (m_st == S_POST) begin
            m_post_cnt++;
            if (m_post_cnt == m_post_total) model_enter_done();
        end
        m_prev = trig_in;
    endtask

    task automatic check_all();
        chk("state_o", int'(state_o), m_st);
        chk("wr_en", int'(wr_en), int'(m_wr));
        chk("wr_addr", int'(wr_addr), m_addr);
        chk("acq_done", int'(acq_done), int'(m_done));
        chk("holdoff_reload_n", int'(holdoff_reload_n), int'(m_rel));
        chk("trig_aft_pul", int'(trig_aft_pul), int'(m_pul));
        chk("trig_addr", int'(trig_addr), m_taddr);
        chk("trig_forced", int'(trig_forced), int'(m_forced));
    endtask

    task automatic cycle(input bit st, input bit sp, input bit tr, input bit ho);
        acq_start = st; acq_stop = sp; trig_in = tr; holdoff_active = ho;
        model_step();
        @(posedge clk_200M);
        #1;
        check_all();
        acq_start = 1'b0; acq_stop = 1'b0;
    endtask

    typedef struct {
        bit start, stop, trig, hold;
        int e_st, e_wr, e_addr, e_done, e_pul, e_rel;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        bit tr, ho;

        // pre=2, post=2 capture with a holdoff-blocked edge, then start+stop collisions
        vecs[0] = '{1, 0, 0, 0, S_PRE,   1, 0, 0, 0, 1};
        vecs[1] = '{0, 0, 1, 0, S_PRE,   1, 1, 0, 0, 1};
        vecs[2] = '{0, 0, 0, 0, S_ARMED, 1, 2, 0, 0, 1};
        vecs[3] = '{0, 0, 1, 1, S_ARMED, 1, 3, 0, 0, 1};
        vecs[4] = '{0, 0, 0, 0, S_ARMED, 1, 4, 0, 0, 1};
        vecs[5] = '{0, 0, 1, 0, S_POST,  1, 5, 0, 0, 1};
        vecs[6] = '{0, 0, 1, 0, S_DONE,  0, 6, 1, 1, 1};
        vecs[7] = '{0, 0, 0, 0, S_DONE,  0, 6, 1, 0, 1};
        vecs[8] = '{1, 1, 0, 0, S_IDLE,  0, 6, 0, 0, 0};
        vecs[9] = '{1, 1, 0, 0, S_IDLE,  0, 6, 0, 0, 0};

        model_reset();
        #11;
        check_all();
        rst = 1'b0;
        #1;

        pre_trig_depth = 4'd2; post_trig_depth = 4'd2; auto_mode = 1'b0; auto_timeout = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].start, vecs[i].stop, vecs[i].trig, vecs[i].hold);
            chk($sformatf("vec%0d_state", i), int'(state_o), vecs[i].e_st);
            chk($sformatf("vec%0d_wr_en", i), int'(wr_en), vecs[i].e_wr);
            chk($sformatf("vec%0d_wr_addr", i), int'(wr_addr), vecs[i].e_addr);
            chk($sformatf("vec%0d_done", i), int'(acq_done), vecs[i].e_done);
            chk($sformatf("vec%0d_pul", i), int'(trig_aft_pul), vecs[i].e_pul);
            chk($sformatf("vec%0d_reload_n", i), int'(holdoff_reload_n), vecs[i].e_rel);
        end
        chk("vec_trig_addr", int'(trig_addr), 4);
        chk("vec_trig_forced", int'(trig_forced), 0);

        // Clamp: pre=14 with post=6 in a 16-deep RAM gives 10 pre-fill writes
        pre_trig_depth = 4'd14; post_trig_depth = 4'd6;
        cycle(1, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 40 && state_o == 3'd1; i++) begin
            n++;
            cycle(0, 0, 0, 0);
        end
        chk("clamp_prefill_cycles", n, 10);
        cycle(0, 1, 0, 0);

        // Auto trigger after timeout 20, post=0 behaves as a single post sample
        pre_trig_depth = 4'd0; post_trig_depth = 4'd0; auto_mode = 1'b1; auto_timeout = 16'd20;
        cycle(1, 0, 0, 0);
        chk("pre0_armed_next", int'(state_o), S_ARMED);
        n = 0;
        for (int i = 0; i < 60 && state_o == 3'd2; i++) begin
            n++;
            cycle(0, 0, 0, 0);
        end
        chk("auto_armed_cycles", n, 21);
        chk("auto_forced", int'(trig_forced), 1);
        chk("auto_post0_done", int'(state_o), S_DONE);

        // Real edge coinciding with the timeout wins
        auto_timeout = 16'd5;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        chk("tie_real_forced", int'(trig_forced), 0);
        chk("tie_real_done", int'(state_o), S_DONE);

        // Abort in POST
        auto_mode = 1'b0; post_trig_depth = 4'd8;
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("abort_in_post", int'(state_o), S_POST);
        cycle(0, 1, 0, 0);
        chk("abort_state", int'(state_o), S_IDLE);
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_reload_n", int'(holdoff_reload_n), 0);
        chk("abort_pul", int'(trig_aft_pul), 0);

        // Asynchronous reset mid pre-fill, between clock edges
        pre_trig_depth = 4'd8; post_trig_depth = 4'd2;
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_state", int'(state_o), S_IDLE);
        chk("async_rst_wr_en", int'(wr_en), 0);
        chk("async_rst_wr_addr", int'(wr_addr), 0);
        chk("async_rst_reload_n", int'(holdoff_reload_n), 0);
        model_reset();
        #1;
        rst = 1'b0;
        cycle(1, 0, 0, 0);
        chk("rearm_after_rst", int'(state_o), S_PRE);

        // Randomized traffic against the model
        tr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                pre_trig_depth  = ADDR_W'($urandom_range(0, 15));
                post_trig_depth = ADDR_W'($urandom_range(0, 15));
                auto_timeout    = TO_W'($urandom_range(0, 30));
            end
            if ($urandom_range(0, 49) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 3) == 0) tr = ~tr;
            ho = ($urandom_range(0, 2) == 0);
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0, tr, ho);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
